// File: rtl/bcd_timer_mux_n.sv
// N-digit BCD time counter with preset load, wrap flag and a rotating word bus.
// Define BCD_TIMER_ALARM_EN to add the alarm_val compare and the alarm pulse.
module bcd_timer_mux_n #(
  parameter int                F_CLK_HZ       = 25_000_000,
  parameter int                TICK_HZ        = 1,
  parameter int                NDIG           = 4,
  parameter logic [4*NDIG-1:0] DIG_MAX        = 16'h2359,
  parameter int                WORD_DWELL_TKS = 12_500_000,
  localparam int               NWORDS         = NDIG / 2,
  localparam int               IDX_W          = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pause,
  input  logic                dir,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
`ifdef BCD_TIMER_ALARM_EN
  input  logic [4*NDIG-1:0]   alarm_val,
  output logic                alarm,
`endif
  output logic [IDX_W+7:0]    word_bus,
  output logic                wrap,
  output logic                led
);

  localparam int TICK_TKS = F_CLK_HZ / TICK_HZ;
  localparam bit TICK_ALL = (TICK_TKS <= 1);
  localparam int TW       = TICK_ALL ? 1 : $clog2(TICK_TKS);
  localparam logic [TW-1:0] TICK_LAST =
    TICK_ALL ? '0 : TW'(TICK_TKS - 1);
  localparam logic [TW-1:0] TICK_HALF =
    TICK_ALL ? '0 : TW'(TICK_TKS / 2);

  localparam bit DWELL_ALL = (WORD_DWELL_TKS <= 1);
  localparam int DW        = DWELL_ALL ? 1 : $clog2(WORD_DWELL_TKS);
  localparam logic [DW-1:0] DWELL_LAST =
    DWELL_ALL ? '0 : DW'(WORD_DWELL_TKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  logic pause_m_q, pause_s_q;
  logic dir_m_q, dir_s_q;
  logic load_m_q, load_s_q, load_p_q;
  logic load_rise, tick, step, adv;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0]    dig_q, dig_d;
  logic [4*NDIG-1:0]    up_v, dn_v, ld_v;
  logic                 cy, bw;
  logic [IDX_W+7:0]     word_q, word_d;
  logic                 wrap_q, wrap_d;
  logic                 led_q, led_d;
`ifdef BCD_TIMER_ALARM_EN
  logic                 alarm_q, alarm_d;
`endif

  assign load_rise = load_s_q & ~load_p_q;
  assign tick      = TICK_ALL | (tick_cnt_q == TICK_LAST);
  assign step      = tick & ~pause_s_q & ~load_rise;
  assign adv       = DWELL_ALL | (dwell_q == DWELL_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (TICK_ALL || load_rise || tick) tick_cnt_d = '0;
    led_d = (tick_cnt_q < TICK_HALF);
  end

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    idx_d   = idx_q;
    if (adv) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Ripple carry/borrow across digits, each with its own modulus.
  always_comb begin
    up_v = dig_q;
    dn_v = dig_q;
    ld_v = load_val;
    cy   = 1'b1;
    bw   = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (cy) begin
        if (dig_q[4*i +: 4] >= DIG_MAX[4*i +: 4]) begin
          up_v[4*i +: 4] = 4'd0;
        end else begin
          up_v[4*i +: 4] = dig_q[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (dig_q[4*i +: 4] == 4'd0) begin
          dn_v[4*i +: 4] = DIG_MAX[4*i +: 4];
        end else begin
          dn_v[4*i +: 4] = dig_q[4*i +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > DIG_MAX[4*i +: 4]) begin
        ld_v[4*i +: 4] = 4'd0;
      end
    end
  end

  always_comb begin
    dig_d  = dig_q;
    wrap_d = 1'b0;
    if (load_rise) begin
      dig_d = ld_v;
    end else if (step) begin
      dig_d  = dir_s_q ? up_v : dn_v;
      wrap_d = dir_s_q ? cy : bw;
    end
`ifdef BCD_TIMER_ALARM_EN
    alarm_d = step & (dig_d == alarm_val);
`endif
  end

  always_comb begin
    word_d = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        word_d = {IDX_W'(k), dig_q[8*k +: 8]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_m_q  <= 1'b0;
      pause_s_q  <= 1'b0;
      dir_m_q    <= 1'b0;
      dir_s_q    <= 1'b0;
      load_m_q   <= 1'b0;
      load_s_q   <= 1'b0;
      load_p_q   <= 1'b0;
      tick_cnt_q <= '0;
      dwell_q    <= '0;
      idx_q      <= '0;
      dig_q      <= '0;
      word_q     <= '0;
      wrap_q     <= 1'b0;
      led_q      <= 1'b0;
`ifdef BCD_TIMER_ALARM_EN
      alarm_q    <= 1'b0;
`endif
    end else begin
      pause_m_q  <= pause;
      pause_s_q  <= pause_m_q;
      dir_m_q    <= dir;
      dir_s_q    <= dir_m_q;
      load_m_q   <= load;
      load_s_q   <= load_m_q;
      load_p_q   <= load_s_q;
      tick_cnt_q <= tick_cnt_d;
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      dig_q      <= dig_d;
      word_q     <= word_d;
      wrap_q     <= wrap_d;
      led_q      <= led_d;
`ifdef BCD_TIMER_ALARM_EN
      alarm_q    <= alarm_d;
`endif
    end
  end

  assign word_bus = word_q;
  assign wrap     = wrap_q;
  assign led      = led_q;
`ifdef BCD_TIMER_ALARM_EN
  assign alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_timer_mux_n.sv
// Bench for bcd_timer_mux_n: directed scenarios plus randomized loads
// checked against a mixed-radix integer model of the counter.
module tb_bcd_timer_mux_n;

  localparam logic [15:0] DM4 = 16'h2359;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val4 = '0;
  logic [23:0] load_val6 = '0;
  logic [8:0]  wb4;
  logic [9:0]  wb6;
  logic        wrap4, wrap6, led4, led6;
`ifdef BCD_TIMER_ALARM_EN
  logic [15:0] alarm_val4 = 16'h0003;
  logic [23:0] alarm_val6 = '0;
  logic        alarm4, alarm6;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wrap_cnt = 0;
  int alarm_cnt = 0;
  int last_e0 = 0;

  bcd_timer_mux_n #(
    .F_CLK_HZ(100), .TICK_HZ(10), .NDIG(4),
    .DIG_MAX(16'h2359), .WORD_DWELL_TKS(1)
  ) u4 (
    .clk(clk), .reset_n(reset_n), .pause(pause), .dir(dir),
    .load(load), .load_val(load_val4),
`ifdef BCD_TIMER_ALARM_EN
    .alarm_val(alarm_val4), .alarm(alarm4),
`endif
    .word_bus(wb4), .wrap(wrap4), .led(led4)
  );

  bcd_timer_mux_n #(
    .F_CLK_HZ(100), .TICK_HZ(10), .NDIG(6),
    .DIG_MAX(24'h235959), .WORD_DWELL_TKS(4)
  ) u6 (
    .clk(clk), .reset_n(reset_n), .pause(pause), .dir(dir),
    .load(load), .load_val(load_val6),
`ifdef BCD_TIMER_ALARM_EN
    .alarm_val(alarm_val6), .alarm(alarm6),
`endif
    .word_bus(wb6), .wrap(wrap6), .led(led6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrap4) wrap_cnt <= wrap_cnt + 1;
`ifdef BCD_TIMER_ALARM_EN
    if (alarm4) alarm_cnt <= alarm_cnt + 1;
`endif
  end

  // Model: the digits form one mixed-radix number, radix i = DIG_MAX[i]+1.
  function automatic int radix(input int i);
    logic [15:0] m;
    m = DM4;
    return int'(m[4*i +: 4]) + 1;
  endfunction

  function automatic int total();
    int t = 1;
    for (int i = 0; i < 4; i++) t *= radix(i);
    return t;
  endfunction

  function automatic int to_int(input logic [15:0] b);
    int v = 0;
    int m = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(b[4*i +: 4]) * m;
      m *= radix(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return r;
  endfunction

  function automatic logic [15:0] clamp4(input logic [15:0] b);
    logic [15:0] r;
    logic [15:0] m;
    m = DM4;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] > m[4*i +: 4]) ? 4'd0 : b[4*i +: 4];
    return r;
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic read4(output logic [15:0] d);
    logic [8:0] s;
    d = '0;
    for (int k = 0; k < 2; k++) begin
      if (k != 0) @(negedge clk);
      s = wb4;
      if (s[8]) d[15:8] = s[7:0];
      else d[7:0] = s[7:0];
    end
  endtask

  // Load acts on the clock edge numbered target (3-flop input path).
  task automatic do_load(input logic [15:0] v4, input logic [23:0] v6,
                         input int target, output int e0);
    wait_to(target - 3);
    load_val4 = v4;
    load_val6 = v6;
    load = 1'b1;
    wait_to(target);
    load = 1'b0;
    e0 = target;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (wb4 !== 9'h0 || wb6 !== 10'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h/%h want 0", wb4, wb6);
    end
    checks++;
    if (wrap4 !== 1'b0 || led4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: wrap %b led %b want 0", wrap4, led4);
    end
`ifdef BCD_TIMER_ALARM_EN
    checks++;
    if (alarm4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_alarm: got %b want 0", alarm4);
    end
`endif
    wait_to(2);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int e0, w0;
    logic [15:0] d;
    dir = 1'b1;
    do_load(16'h2358, 24'h0, cyc + 6, e0);
    w0 = wrap_cnt;
    wait_to(e0 + 5);
    read4(d);
    checks++;
    if (d !== 16'h2358) begin
      errors++; $display("FAIL up_load: got %h want 2358", d);
    end
    wait_to(e0 + 15);
    read4(d);
    checks++;
    if (d !== 16'h2359) begin
      errors++; $display("FAIL up_step1: got %h want 2359", d);
    end
    wait_to(e0 + 20);
    checks++;
    if (wrap4 !== 1'b1) begin
      errors++; $display("FAIL up_wrap_hi: got %b want 1", wrap4);
    end
    wait_to(e0 + 21);
    checks++;
    if (wrap4 !== 1'b0) begin
      errors++; $display("FAIL up_wrap_lo: got %b want 0", wrap4);
    end
    wait_to(e0 + 25);
    read4(d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL up_step2: got %h want 0000", d);
    end
    checks++;
    if (wrap_cnt - w0 != 1) begin
      errors++; $display("FAIL up_wrap_cnt: got %0d want 1", wrap_cnt - w0);
    end
  endtask

  task automatic test_down_wrap();
    int e0;
    logic [15:0] d;
    dir = 1'b0;
    do_load(16'h0000, 24'h0, cyc + 6, e0);
    wait_to(e0 + 5);
    read4(d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL dn_load: got %h want 0000", d);
    end
    wait_to(e0 + 10);
    checks++;
    if (wrap4 !== 1'b1) begin
      errors++; $display("FAIL dn_wrap_hi: got %b want 1", wrap4);
    end
    wait_to(e0 + 11);
    checks++;
    if (wrap4 !== 1'b0) begin
      errors++; $display("FAIL dn_wrap_lo: got %b want 0", wrap4);
    end
    wait_to(e0 + 15);
    read4(d);
    checks++;
    if (d !== 16'h2359) begin
      errors++; $display("FAIL dn_step1: got %h want 2359", d);
    end
    wait_to(e0 + 25);
    read4(d);
    checks++;
    if (d !== 16'h2358) begin
      errors++; $display("FAIL dn_step2: got %h want 2358", d);
    end
    last_e0 = e0;
  endtask

  task automatic test_load_priority();
    int e1, w0;
    logic [15:0] d;
    dir = 1'b1;
    do_load(16'h2A7B, 24'h0, last_e0 + 30, e1);
    w0 = wrap_cnt;
    wait_to(e1 + 2);
    read4(d);
    checks++;
    if (d !== 16'h2000) begin
      errors++; $display("FAIL clamp_load: got %h want 2000", d);
    end
    wait_to(e1 + 9);
    read4(d);
    checks++;
    if (d !== 16'h2000) begin
      errors++; $display("FAIL clamp_hold: got %h want 2000", d);
    end
    wait_to(e1 + 11);
    read4(d);
    checks++;
    if (d !== 16'h2001) begin
      errors++; $display("FAIL clamp_next: got %h want 2001", d);
    end
    checks++;
    if (wrap_cnt != w0) begin
      errors++; $display("FAIL clamp_wrap: got %0d want 0", wrap_cnt - w0);
    end
  endtask

  task automatic test_pause();
    int e0, hi;
    logic [15:0] d;
    dir = 1'b1;
    do_load(16'h1234, 24'h0, cyc + 6, e0);
    wait_to(e0 + 1);
    pause = 1'b1;
    wait_to(e0 + 5);
    read4(d);
    checks++;
    if (d !== 16'h1234) begin
      errors++; $display("FAIL pause_load: got %h want 1234", d);
    end
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      wait_to(e0 + 7 + i);
      if (cyc == e0 + 32) pause = 1'b0;
      if (led4 === 1'b1) hi++;
    end
    checks++;
    if (hi != 15) begin
      errors++; $display("FAIL pause_led: got %0d high want 15", hi);
    end
    wait_to(e0 + 37);
    read4(d);
    checks++;
    if (d !== 16'h1234) begin
      errors++; $display("FAIL pause_hold: got %h want 1234", d);
    end
    wait_to(e0 + 45);
    read4(d);
    checks++;
    if (d !== 16'h1235) begin
      errors++; $display("FAIL pause_resume: got %h want 1235", d);
    end
  endtask

  task automatic test_mux();
    int e0, j;
    logic [9:0] s[44];
    logic [9:0] seq[3];
    seq[0] = 10'h056;
    seq[1] = 10'h134;
    seq[2] = 10'h212;
    pause = 1'b1;
    do_load(16'h0, 24'h123456, cyc + 6, e0);
    for (int i = 0; i < 44; i++) begin
      wait_to(e0 + 2 + i);
      s[i] = wb6;
    end
    j = -1;
    for (int i = 1; i < 28; i++)
      if (j < 0 && s[i] == 10'h056 && s[i-1] != 10'h056) j = i;
    if (j < 0) begin
      checks++;
      errors++;
      $display("FAIL mux_find: got %h want 056 start", s[0]);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (s[j+k] !== seq[(k/4)%3]) begin
          errors++;
          $display("FAIL mux_word%0d: got %h want %h",
                   k, s[j+k], seq[(k/4)%3]);
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    int e0, w0, a0, ns, v, ew, ea, mode;
    logic [15:0] lv, d, exp;
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: lv = 16'($urandom);
        1: lv = 16'h2359;
        2: lv = 16'h0000;
        default: lv = 16'h2358;
      endcase
      dir = 1'($urandom_range(0, 1));
      ns = $urandom_range(1, 3);
      do_load(lv, 24'h0, cyc + 6 + $urandom_range(0, 9), e0);
      w0 = wrap_cnt;
      a0 = alarm_cnt;
      v = to_int(clamp4(lv));
      ew = 0;
      ea = 0;
      for (int s = 0; s < ns; s++) begin
        if (dir) begin
          if (v == total() - 1) ew++;
          v = (v + 1) % total();
        end else begin
          if (v == 0) ew++;
          v = (v + total() - 1) % total();
        end
        if (to_bcd(v) == 16'h0003) ea++;
      end
      exp = to_bcd(v);
      wait_to(e0 + 10*ns + 5);
      read4(d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL rnd%0d_digits: got %h want %h (load %h dir %b n %0d)",
                 it, d, exp, lv, dir, ns);
      end
      wait_to(e0 + 10*ns + 7);
      checks++;
      if (wrap_cnt - w0 != ew) begin
        errors++;
        $display("FAIL rnd%0d_wrap: got %0d want %0d", it, wrap_cnt - w0, ew);
      end
`ifdef BCD_TIMER_ALARM_EN
      checks++;
      if (alarm_cnt - a0 != ea) begin
        errors++;
        $display("FAIL rnd%0d_alarm: got %0d want %0d",
                 it, alarm_cnt - a0, ea);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int e0, rs, a0;
    logic [15:0] d;
    dir = 1'b1;
    do_load(16'h1234, 24'h0, cyc + 6, e0);
    wait_to(e0 + 4);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (wb4 !== 9'h0 || wb6 !== 10'h0) begin
      errors++; $display("FAIL mid_reset_bus: got %h/%h want 0", wb4, wb6);
    end
    checks++;
    if (wrap4 !== 1'b0 || led4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: wrap %b led %b want 0", wrap4, led4);
    end
    wait_to(cyc + 2);
    reset_n = 1'b1;
    rs = cyc;
    a0 = alarm_cnt;
    wait_to(rs + 5);
    read4(d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL mid_restart: got %h want 0000", d);
    end
    wait_to(rs + 15);
    read4(d);
    checks++;
    if (d !== 16'h0001) begin
      errors++; $display("FAIL mid_tick1: got %h want 0001", d);
    end
    wait_to(rs + 25);
    read4(d);
    checks++;
    if (d !== 16'h0002) begin
      errors++; $display("FAIL mid_tick2: got %h want 0002", d);
    end
`ifdef BCD_TIMER_ALARM_EN
    wait_to(rs + 30);
    checks++;
    if (alarm4 !== 1'b1) begin
      errors++; $display("FAIL alarm_hi: got %b want 1", alarm4);
    end
    wait_to(rs + 31);
    checks++;
    if (alarm4 !== 1'b0) begin
      errors++; $display("FAIL alarm_lo: got %b want 0", alarm4);
    end
    wait_to(rs + 47);
    checks++;
    if (alarm_cnt - a0 != 1) begin
      errors++; $display("FAIL alarm_cnt: got %0d want 1", alarm_cnt - a0);
    end
`else
    a0 = a0 + 0;
`endif
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_pause();
    test_mux();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_timer_mux_n.md
Name: bcd_timer_mux_n

Overview:
Parametrised N-digit BCD time counter with a per-digit modulus, up/down counting, pause and synchronous preset load. It time-multiplexes the digit pairs onto one narrow word bus, with a word-index prefix in the MSBs for the downstream display/decoder board. It is the generalised successor of the fixed 4-digit MM:SS-style counter. It adds arbitrary digit count, preset load, a wrap flag, and an N-word bus rotation instead of a 2-word rotation.

Parameters:
F_CLK_HZ, 25_000_000, board clock frequency in Hz
TICK_HZ, 1, count rate; TICK_TKS = F_CLK_HZ/TICK_HZ (TICK_TKS <= 1 means count every cycle)
NDIG, 4, digit count; even, 2..8; NWORDS = NDIG/2
DIG_MAX, 16'h2359, packed per-digit maximum, 4*NDIG bits; digit 0 (units) in bits [3:0]; each nibble 1..9
WORD_DWELL_TKS, 12_500_000, clk cycles each bus word is held
IDX_W, derived: max(1, clog2(NWORDS)); not overridable

Ports:
clk  in  1  board clock
reset_n  in  1  asynchronous active-low reset
pause  in  1  async level input; 1 freezes digits
dir  in  1  async level input; 1 = count up, 0 = count down
load  in  1  async input; rising edge presets digits from load_val
load_val  in  4*NDIG  preset value, quasi-static around load
word_bus  out  IDX_W+8  {word index, digit[2k+1], digit[2k]}
wrap  out  1  one-cycle pulse on counter wrap-around
led  out  1  heartbeat: high during the first half of each tick period

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (reset_n). Assertion immediately clears all flops: digits = 0, tick/dwell counters = 0, word index = 0, word_bus = 0, wrap = 0, led = 0, synchronisers = 0.
- pause, dir, load: each passes through a 2-flop synchroniser. load_rise = rising edge of synchronised load, detected with one extra flop, so 3 cycles input-to-action. A held load loads once.
- Tick counter: counts 0..TICK_TKS-1; tick = 1 on the terminal value, then the counter wraps to 0. load_rise clears the counter, so the first step after a load comes a full period later.
- Priority per cycle: load_rise > (tick & !pause_s) > hold.
- Load: each nibble i of load_val is written to digit i. A nibble above DIG_MAX[i] loads 0. No wrap pulse.
- Count up: digit 0 increments. A digit at its max rolls to 0 and carries into the next digit. Carry out of digit NDIG-1 (all digits at max) gives all zeros and wrap = 1 for one cycle.
- Count down: symmetric borrow. A digit at 0 reloads its max. All zeros gives all digits = DIG_MAX and wrap = 1.
- Pause: holds the digits. The tick, dwell and led counters keep running.
- dir change takes effect on the next count step. A dir change together with a tick uses the synchronised dir value of that cycle.
- Mux: the dwell counter counts 0..WORD_DWELL_TKS-1. At its terminal value the word index increments, wrapping NWORDS-1 -> 0.
- word_bus is registered each clk as {idx, digit[2*idx+1], digit[2*idx]}, one cycle after the digit or index change.
- led: registered, = (tick counter < TICK_TKS/2).
- Reset mid-operation: immediate clear. Counting resumes from 0000 after release, with tick and dwell restarting at 0.

Optional Feature:
Macro BCD_TIMER_ALARM_EN.
- Defined: adds input alarm_val (4*NDIG) and output alarm (1, reset 0). alarm pulses for one cycle when a count step (not a load) makes the digits equal alarm_val. The pulse is coincident with wrap if both apply.
- Undefined: neither port exists, and no compare logic is built.

Test Plan:
- Up wrap (F_CLK_HZ=100, TICK_HZ=10, NDIG=4, DIG_MAX=16'h2359): load 16'h2358, dir=1 -> after 1 tick digits = 2359; after the next tick digits = 0000 and wrap high for exactly 1 cycle.
- Down wrap: load 16'h0000, dir=0 -> next tick digits = 2359, wrap 1 cycle; following tick = 2358.
- Load clamp and priority: load_val=16'h2A7B, with load_rise on the same cycle as tick -> digits = 2000, no count step that cycle, next step exactly TICK_TKS cycles later.
- Mux rotation (NDIG=6, DIG_MAX=24'h235959, WORD_DWELL_TKS=4, digits 12:34:56) -> word_bus sequence 10'h056, 10'h134, 10'h212, then 10'h056 again, each held 4 cycles.
- Pause held for 3 ticks -> digits unchanged; led keeps toggling. Release -> next tick counts normally.
- Async reset_n low mid-count, no clock edge -> word_bus, wrap, led = 0 immediately. With BCD_TIMER_ALARM_EN and alarm_val=16'h0003: after release, alarm pulses on the 3rd tick only.
